// File: rtl/dmem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_req_arbiter
// Description : Two-lane front end for the single-port data RAM. Each lane
//               owns a one-entry request buffer. One buffered request per
//               clock is granted onto the RAM port. Same-address ordering
//               follows buffer age, lane 2 is protected against starvation,
//               and read data is routed back to the lane that issued it.
// Revision    : 1.0 - initial single-edge implementation
// ============================================================================
module dmem_req_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST,
  // lane 1 request
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              req1_ready,
  // lane 2 request
  input  logic              req2_valid,
  input  logic              req2_rw,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [31:0]       req2_wdata,
  output logic              req2_ready,
  // read responses
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_data,
  output logic              rsp2_valid,
  output logic [31:0]       rsp2_data,
  // RAM port
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);
  localparam logic [3:0] C_STARVE_SAT = 4'hF;

  // request buffers
  logic              r_full1, r_full2;
  logic              r_rw1, r_rw2;
  logic [ADDR_W-1:0] r_addr1, r_addr2;
  logic [31:0]       r_wdata1, r_wdata2;

  // set when buffer 2 holds the older request
  logic              r_older2;
  logic [3:0]        r_starve2;

  // read issued last cycle, tagged with its owning lane
  logic              r_rd1, r_rd2;

  logic w_grant1, w_grant2;
  logic w_hazard, w_starved;
  logic w_acc1, w_acc2;
  logic w_vacant1, w_vacant2;

  assign w_hazard  = r_full1 && r_full2 && (r_addr1 == r_addr2) && (!r_rw1 || !r_rw2);
  assign w_starved = (r_starve2 >= C_STARVE_MAX);

  // A buffer is vacant for this cycle when it is empty or is being issued now.
  assign w_vacant1 = ~r_full1 | w_grant1;
  assign w_vacant2 = ~r_full2 | w_grant2;

  // Ready is a function of buffer state only, so a granted buffer can refill
  // in the same cycle and sustain one request per clock per lane.
  assign req1_ready = ~RST & w_vacant1;
  assign req2_ready = ~RST & w_vacant2;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_acc2     = req2_valid & req2_ready;

  // Grant selection: age decides on a same-address hazard, otherwise lane 1
  // wins unless lane 2 has lost too many times in a row.
  always_comb begin
    w_grant1 = 1'b0;
    w_grant2 = 1'b0;
    if (!RST) begin
      if (r_full1 && r_full2) begin
        if (w_hazard) begin
          w_grant2 = r_older2;
          w_grant1 = ~r_older2;
        end else begin
          w_grant2 = w_starved;
          w_grant1 = ~w_starved;
        end
      end else begin
        w_grant1 = r_full1;
        w_grant2 = r_full2;
      end
    end
  end

  // Lane 1 buffer: load on accept, empty once issued without a refill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_full1  <= 1'b0;
      r_rw1    <= 1'b1;
      r_addr1  <= '0;
      r_wdata1 <= '0;
    end else if (w_acc1) begin
      r_full1  <= 1'b1;
      r_rw1    <= req1_rw;
      r_addr1  <= req1_addr;
      r_wdata1 <= req1_wdata;
    end else if (w_grant1) begin
      r_full1  <= 1'b0;
    end
  end

  // Lane 2 buffer: load on accept, empty once issued without a refill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_full2  <= 1'b0;
      r_rw2    <= 1'b1;
      r_addr2  <= '0;
      r_wdata2 <= '0;
    end else if (w_acc2) begin
      r_full2  <= 1'b1;
      r_rw2    <= req2_rw;
      r_addr2  <= req2_addr;
      r_wdata2 <= req2_wdata;
    end else if (w_grant2) begin
      r_full2  <= 1'b0;
    end
  end

  // Age tracking. A lane that fills while the other buffer stays occupied is
  // the younger one, so the flag also follows a refill that lands behind a
  // still-pending request on the other lane. Simultaneous fills favour lane 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_older2 <= 1'b0;
    end else if (w_acc1 && w_acc2) begin
      r_older2 <= 1'b0;
    end else if (w_acc2) begin
      r_older2 <= w_vacant1;
    end else if (w_acc1) begin
      r_older2 <= ~w_vacant2;
    end
  end

  // Lane-2 starvation counter: counts losses while pending, saturating.
  always_ff @(posedge CLK) begin
    if (RST || w_grant2) begin
      r_starve2 <= '0;
    end else if (r_full2 && (r_starve2 != C_STARVE_SAT)) begin
      r_starve2 <= r_starve2 + 4'd1;
    end
  end

  // Remember which lane owns the read issued this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd1 <= 1'b0;
      r_rd2 <= 1'b0;
    end else begin
      r_rd1 <= w_grant1 & r_rw1;
      r_rd2 <= w_grant2 & r_rw2;
    end
  end

  // Responses are masked by reset so a read in flight at reset never returns.
  assign rsp1_valid = r_rd1 & ~RST;
  assign rsp2_valid = r_rd2 & ~RST;
  assign rsp1_data  = rsp1_valid ? ram_rdata : 32'h0;
  assign rsp2_data  = rsp2_valid ? ram_rdata : 32'h0;

  // RAM port drive from the granted buffer; idle value is a deselected read.
  always_comb begin
    ram_cs    = 1'b0;
    ram_rw    = 1'b1;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_grant1) begin
      ram_cs    = 1'b1;
      ram_rw    = r_rw1;
      ram_addr  = r_addr1;
      ram_wdata = r_rw1 ? 32'h0 : r_wdata1;
    end else if (w_grant2) begin
      ram_cs    = 1'b1;
      ram_rw    = r_rw2;
      ram_addr  = r_addr2;
      ram_wdata = r_rw2 ? 32'h0 : r_wdata2;
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_req_arbiter.md
Name: dmem_req_arbiter

Overview:
- Requester-side front end for the single-port data RAM.
- Accepts load/store requests from two pipeline lanes through valid/ready handshakes and holds each in a one-entry buffer.
- Serialises the requests onto the RAM port one per clock and returns read data to the lane that issued it.
- Replaces dual-edge time multiplexing with single-edge arbitration, starvation control and same-address ordering.

Parameters:
- ADDR_W, 12, RAM word-address width.
- STARVE_MAX, 3, consecutive lane-2 losses (with lane 2 pending) before lane 2 is forced a grant; range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req1_valid  in  1  lane-1 request present.
- req1_rw  in  1  0 = write, 1 = read.
- req1_addr  in  ADDR_W  word address.
- req1_wdata  in  32  store data; ignored on reads.
- req1_ready  out  1  lane-1 buffer can accept this cycle.
- req2_valid, req2_rw, req2_addr, req2_wdata, req2_ready: same as lane 1, for lane 2.
- rsp1_valid  out  1  lane-1 read data valid; one-cycle pulse.
- rsp1_data  out  32  lane-1 read data.
- rsp2_valid, rsp2_data: same as lane 1, for lane 2.
- ram_cs  out  1  RAM select.
- ram_rw  out  1  0 = write, 1 = read.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after a read select (synchronous read).

Behaviour:
- Buffers:
  - Each lane has a buffer holding full, rw, addr, wdata and age.
  - Accept when reqN_valid && reqN_ready; the buffer is full from the next cycle.
  - reqN_ready = ~RST && (~fullN || grantN). It depends on state only, never on reqN_valid.
  - A granted buffer may refill in its grant cycle, giving one request per cycle per lane.
- Age:
  - A one-bit "lane-2 older" flag is set when buffer 2 fills while buffer 1 is empty or granted.
  - It is cleared when buffer 1 fills while buffer 2 is empty or granted.
  - If both lanes are accepted in the same cycle, lane 1 is older.
- Grant (combinational from buffer state, at most one per cycle):
  - One buffer full: grant it.
  - Both full, same addr, at least one write (hazard): grant the older buffer; starvation override ignored.
  - Both full, no hazard: grant lane 2 if starve2 >= STARVE_MAX, otherwise lane 1.
- starve2 (4-bit):
  - Increments, saturating at 15, each cycle buffer 2 is full and not granted.
  - Cleared on grant2 or RST.
- RAM drive:
  - In the grant cycle: ram_cs=1, ram_rw=buf.rw, ram_addr=buf.addr, ram_wdata=buf.wdata (0 when rw=1).
  - No grant: ram_cs=0, ram_rw=1, ram_addr=0, ram_wdata=0.
- Response:
  - A read granted in cycle G gives rspN_valid=1 in cycle G+1, with rspN_data=ram_rdata; rspN_data=0 otherwise.
  - Writes produce no response.
  - The lane owner of the in-flight read is registered at G.
- Latency: read accepted at T with no contention gives grant at T+1 and response at T+2.
- Reset:
  - Reset values: buffers empty, age=0, starve2=0, in-flight flags 0.
  - During RST: all outputs 0 except ram_rw=1; req ready=0.
  - RST during an in-flight read suppresses its response. Pending requests are discarded, not issued.
  - Ready rises the first cycle after RST falls.
- Simultaneous grant and refill of the same lane: the new request is buffered and old data is issued; there is no overlap hazard.

Test Plan:
- Lane-1 write addr 0x010 data 0xDEADBEEF, then read 0x010 -> write issued T+1 with ram_rw=0; rsp1_valid at read-accept+2 with 0xDEADBEEF; rsp2_valid never high.
- Lane-1 reads 0x000..0x007 held valid every cycle -> ram_cs high 8 consecutive cycles; 8 consecutive rsp1 pulses in order; req1_ready never low.
- Both lanes issue continuous reads to distinct addresses, STARVE_MAX=3 -> grant pattern 1,1,1,2 repeating; lane 2 gets exactly 1 of every 4 grants; all data returned to the correct lane.
- Same-cycle accept: lane-1 write 0x020=0x00001234, lane-2 read 0x020 -> lane 1 issued first, rsp2_data=0x00001234. Then lane-2 read 0x030 accepted one cycle before lane-1 write 0x030 (while lane 1 is busy) -> the read issues first and returns the old value.
- Lane-2 read granted, RST high the next cycle -> rsp2_valid stays 0; ram_cs=0 and both ready=0 during RST; buffers empty after; first post-reset request serviced normally.
- Lane-2 write-only burst of 4 -> 4 ram_cs pulses with ram_rw=0 and no rsp pulses; starve2 stays 0.
